// File: rtl/mr1_bus_pkg.sv
// Shared types for the MR1 bus arbiter.
//   reqId_e  : which requester issued a read (routes the response back)
//   SIZE_*   : access size encodings used on the command payload
//   memCmd_t : command payload carried from a requester to the memory port
package mr1_bus_pkg;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } reqId_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } memCmd_t;

endpackage

// File: rtl/mr1_bus_id_fifo.sv
// In-order ID FIFO: remembers which requester owns each outstanding read.
//   clk, reset : clock, async active-high reset (empties the FIFO)
//   push, din  : enqueue din (ignored when full unless popping the same cycle)
//   pop, dout  : dequeue; dout is the head entry, valid while !empty
//   full, empty, count : occupancy
module mr1_bus_id_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 1,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr, rdPtr;
  logic             doPush, doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign doPop  = pop && !empty;
  // A pop frees the slot in the same cycle, so push-while-full is legal then.
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/mr1_bus_arbiter.sv
// Shares one memory port between the MR1 iBus (fetch) and dBus (load/store).
// Commands pass combinationally after arbitration; read responses return in
// order and are steered by an ID FIFO. dBus wins contention unless iBus has
// lost STARVE_LIMIT arbitration cycles in a row.
//   clk, reset          : clock, async active-high reset
//   iBus_cmd_* / rsp_*  : fetch command and instruction return
//   dBus_cmd_* / rsp_*  : load/store command and load data return
//   mem_cmd_* / rsp_*   : shared memory port (in-order responses)
//   err_unexpected_rsp  : sticky, response seen with nothing outstanding
module mr1_bus_arbiter
  import mr1_bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iBus_cmd_valid,
  output logic        iBus_cmd_ready,
  input  logic [31:0] iBus_cmd_payload_pc,
  output logic        iBus_rsp_ready,
  output logic [31:0] iBus_rsp_inst,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic        dBus_cmd_payload_wr,
  input  logic [31:0] dBus_cmd_payload_address,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [1:0]  dBus_cmd_payload_size,
  output logic        dBus_rsp_ready,
  output logic [31:0] dBus_rsp_data,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_wr,
  output logic [31:0] mem_cmd_addr,
  output logic [31:0] mem_cmd_wdata,
  output logic [1:0]  mem_cmd_size,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        err_unexpected_rsp
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic          locked;
  reqId_e        lockOwner;
  logic [SW-1:0] starveCnt;
  logic          errFlag;

  logic          fifoFull, fifoEmpty, fifoPush, rspPop;
  logic [CW-1:0] fifoCount;
  logic [0:0]    headId;
  reqId_e        pushId;

  logic          iElig, dElig, grantI, grantD;
  memCmd_t       iCmd, dCmd, selCmd;

  assign iCmd = '{wr: 1'b0, addr: iBus_cmd_payload_pc, wdata: 32'd0, size: SIZE_W};
  assign dCmd = '{wr: dBus_cmd_payload_wr, addr: dBus_cmd_payload_address,
                  wdata: dBus_cmd_payload_data, size: dBus_cmd_payload_size};

  // Reads are held back while the ID FIFO is full; stores always go.
  assign iElig = iBus_cmd_valid && !fifoFull;
  assign dElig = dBus_cmd_valid && (dBus_cmd_payload_wr || !fifoFull);

  always_comb begin
    grantI = 1'b0;
    grantD = 1'b0;
    if (reset) begin
      grantI = 1'b0;
    end else if (locked) begin
      // A stalled handshake keeps its owner; the other side cannot sneak in.
      grantI = (lockOwner == REQ_I) && iElig;
      grantD = (lockOwner == REQ_D) && dElig;
    end else if (iElig && dElig) begin
      if (starveCnt == SW'(STARVE_LIMIT)) grantI = 1'b1;
      else                                grantD = 1'b1;
    end else begin
      grantI = iElig;
      grantD = dElig;
    end
  end

  assign selCmd         = grantD ? dCmd : (grantI ? iCmd : '0);
  assign mem_cmd_valid  = grantI || grantD;
  assign mem_cmd_wr     = selCmd.wr;
  assign mem_cmd_addr   = selCmd.addr;
  assign mem_cmd_wdata  = selCmd.wdata;
  assign mem_cmd_size   = selCmd.size;
  assign iBus_cmd_ready = grantI && mem_cmd_ready;
  assign dBus_cmd_ready = grantD && mem_cmd_ready;

  assign fifoPush = mem_cmd_valid && mem_cmd_ready && !mem_cmd_wr;
  assign pushId   = grantD ? REQ_D : REQ_I;
  assign rspPop   = mem_rsp_valid && !fifoEmpty;

  mr1_bus_id_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(1)) idFifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifoPush),
    .pop   (rspPop),
    .din   (pushId),
    .dout  (headId),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  assign iBus_rsp_ready     = rspPop && (headId == REQ_I);
  assign dBus_rsp_ready     = rspPop && (headId == REQ_D);
  assign iBus_rsp_inst      = mem_rsp_data;
  assign dBus_rsp_data      = mem_rsp_data;
  assign err_unexpected_rsp = errFlag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked    <= 1'b0;
      lockOwner <= REQ_I;
      starveCnt <= '0;
      errFlag   <= 1'b0;
    end else begin
      locked <= mem_cmd_valid && !mem_cmd_ready;
      if (mem_cmd_valid && !mem_cmd_ready) lockOwner <= pushId;

      if (grantI && mem_cmd_ready)
        starveCnt <= '0;
      else if (iBus_cmd_valid && grantD && starveCnt != SW'(STARVE_LIMIT))
        starveCnt <= starveCnt + 1'b1;

      if (mem_rsp_valid && fifoCount == '0) errFlag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mr1_bus_arbiter.sv
module tb_mr1_bus_arbiter;

  localparam int MAXO = 2;
  localparam int SLIM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iv = 1'b0, dv = 1'b0, dwr = 1'b0, mready = 1'b0, rv = 1'b0;
  logic [31:0] pc = '0, daddr = '0, dwdata = '0, rdata = '0;
  logic [1:0]  dsize = '0;

  logic        iRdy, dRdy, iRsp, dRsp, mValid, mWr, err;
  logic [31:0] iInst, dData, mAddr, mWdata;
  logic [1:0]  mSize;

  mr1_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .reset(reset),
    .iBus_cmd_valid(iv), .iBus_cmd_ready(iRdy), .iBus_cmd_payload_pc(pc),
    .iBus_rsp_ready(iRsp), .iBus_rsp_inst(iInst),
    .dBus_cmd_valid(dv), .dBus_cmd_ready(dRdy), .dBus_cmd_payload_wr(dwr),
    .dBus_cmd_payload_address(daddr), .dBus_cmd_payload_data(dwdata),
    .dBus_cmd_payload_size(dsize), .dBus_rsp_ready(dRsp), .dBus_rsp_data(dData),
    .mem_cmd_valid(mValid), .mem_cmd_ready(mready), .mem_cmd_wr(mWr),
    .mem_cmd_addr(mAddr), .mem_cmd_wdata(mWdata), .mem_cmd_size(mSize),
    .mem_rsp_valid(rv), .mem_rsp_data(rdata), .err_unexpected_rsp(err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model: outstanding reads (0 = iBus, 1 = dBus), the requester
  // holding a stalled handshake (-1 none), cycles iBus has lost, error flag.
  int q[$];
  int held = -1;
  int starve = 0;
  bit errM = 0;

  // Outputs sampled by the last cycle step.
  logic        sMV, sIRdy, sDRdy, sWr, sIrsp, sDrsp;
  logic [31:0] sAddr, sInst;
  logic [1:0]  sSize;

  task automatic chk1(string tag, logic obs, logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    q.delete();
    held = -1;
    starve = 0;
    errM = 0;
  endtask

  // One clock cycle: inputs already driven; check outputs against the model,
  // advance the model, then move to just after the next rising edge.
  task automatic cyc();
    int  win, id;
    bit  full, iOk, dOk, acc;
    #2;
    full = (q.size() >= MAXO);
    iOk  = iv && !full;
    dOk  = dv && (dwr || !full);
    win  = -1;
    if (held == 0)          win = iOk ? 0 : -1;
    else if (held == 1)     win = dOk ? 1 : -1;
    else if (iOk && dOk)    win = (starve == SLIM) ? 0 : 1;
    else if (iOk)           win = 0;
    else if (dOk)           win = 1;

    chk1("mem_cmd_valid", mValid, win >= 0);
    chk1("iBus_cmd_ready", iRdy, win == 0 && mready);
    chk1("dBus_cmd_ready", dRdy, win == 1 && mready);
    if (win == 0) begin
      chk32("i addr", mAddr, pc);
      chk1("i wr", mWr, 1'b0);
      chk32("i size", 32'(mSize), 32'd2);
    end else if (win == 1) begin
      chk32("d addr", mAddr, daddr);
      chk1("d wr", mWr, dwr);
      chk32("d size", 32'(mSize), 32'(dsize));
      if (dwr) chk32("d wdata", mWdata, dwdata);
    end
    id = -1;
    if (rv && q.size() > 0) id = q[0];
    chk1("iBus_rsp_ready", iRsp, id == 0);
    chk1("dBus_rsp_ready", dRsp, id == 1);
    if (rv) begin
      chk32("iBus_rsp_inst", iInst, rdata);
      chk32("dBus_rsp_data", dData, rdata);
    end
    chk1("err_unexpected_rsp", err, errM);

    sMV = mValid; sIRdy = iRdy; sDRdy = dRdy; sWr = mWr; sAddr = mAddr;
    sSize = mSize; sIrsp = iRsp; sDrsp = dRsp; sInst = iInst;

    acc = (win >= 0) && mready;
    if (rv) begin
      if (q.size() > 0) void'(q.pop_front());
      else errM = 1;
    end
    if (acc && (win == 0 || !dwr)) q.push_back(win);
    held = (win >= 0 && !mready) ? win : -1;
    if (win == 0 && acc)                    starve = 0;
    else if (iv && win == 1 && starve < SLIM) starve++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iv = 0; dv = 0; dwr = 0; mready = 1; rv = 0; rdata = '0;
  endtask

  // Asserts reset wherever we are in the cycle, checks outputs collapse at
  // once, then releases it just after a rising edge.
  task automatic doReset();
    reset = 1;
    #1;
    chk1("rst mem_cmd_valid", mValid, 1'b0);
    chk1("rst iBus_cmd_ready", iRdy, 1'b0);
    chk1("rst dBus_cmd_ready", dRdy, 1'b0);
    chk1("rst iBus_rsp_ready", iRsp, 1'b0);
    chk1("rst dBus_rsp_ready", dRsp, 1'b0);
    chk1("rst err", err, 1'b0);
    modelClear();
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    iv = 1; dv = 1; mready = 1;
    @(posedge clk);
    #1;
    doReset();

    // iBus alone, response two cycles later.
    iv = 1; pc = 32'h100; mready = 1; cyc();
    chk32("t1 addr", sAddr, 32'h100);
    chk32("t1 size", 32'(sSize), 32'd2);
    chk1("t1 wr", sWr, 1'b0);
    idle(); cyc();
    rv = 1; rdata = 32'h13; cyc();
    chk1("t1 irsp", sIrsp, 1'b1);
    chk32("t1 inst", sInst, 32'h13);
    chk1("t1 drsp", sDrsp, 1'b0);
    idle(); cyc();

    // Both valid, memory stalls three cycles: dBus keeps the lock.
    doReset();
    for (int k = 0; k < 4; k++) begin
      iv = (k < 3); pc = 32'h300; dv = 1; dwr = 1; daddr = 32'h200;
      dwdata = 32'hDEAD; dsize = 2'd1; mready = (k == 3);
      cyc();
      chk32("t2 addr stable", sAddr, 32'h200);
      chk1("t2 iready", sIRdy, 1'b0);
    end
    chk1("t2 dready", sDRdy, 1'b1);
    idle(); cyc();

    // Continuous dBus loads vs waiting iBus: 4 dBus grants then iBus.
    doReset();
    for (int k = 0; k < 6; k++) begin
      iv = 1; pc = 32'h400; dv = 1; dwr = 0; daddr = 32'h500 + 32'(k * 4);
      dsize = 2'd2; mready = 1; rv = (k > 0); rdata = 32'(k);
      cyc();
      if (k == 4) chk1("t3 iBus wins", sIRdy, 1'b1);
      else        chk1("t3 dBus wins", sDRdy, 1'b1);
    end
    idle(); rv = 1; cyc();
    idle(); cyc();

    // FIFO full: third load held, store passes, responses route D, D, D.
    doReset();
    dv = 1; dwr = 0; dsize = 2'd2; mready = 1;
    daddr = 32'h10; cyc();
    daddr = 32'h14; cyc();
    daddr = 32'h18; cyc();
    chk1("t4 load gated", sMV, 1'b0);
    dwr = 1; daddr = 32'h1C; dwdata = 32'h55; cyc();
    chk1("t4 store accepted", sDRdy, 1'b1);
    dwr = 0; daddr = 32'h18; rv = 1; rdata = 32'h111; cyc();
    chk1("t4 load still gated", sMV, 1'b0);
    chk1("t4 rsp1 to D", sDrsp, 1'b1);
    rv = 0; cyc();
    chk1("t4 load accepted", sDRdy, 1'b1);
    dv = 0; rv = 1; rdata = 32'h222; cyc();
    chk1("t4 rsp2 to D", sDrsp, 1'b1);
    rdata = 32'h333; cyc();
    chk1("t4 rsp3 to D", sDrsp, 1'b1);
    idle(); cyc();

    // Interleaved I-read, D-read, D-store, I-read.
    doReset();
    iv = 1; pc = 32'h40; cyc();
    iv = 0; dv = 1; dwr = 0; daddr = 32'h80; cyc();
    dwr = 1; daddr = 32'h84; dwdata = 32'h77; rv = 1; rdata = 32'hA; cyc();
    chk1("t5 store acc", sDRdy, 1'b1);
    chk1("t5 A to I", sIrsp, 1'b1);
    chk32("t5 A data", sInst, 32'hA);
    dv = 0; iv = 1; pc = 32'h44; rv = 0; cyc();
    chk1("t5 I read acc", sIRdy, 1'b1);
    iv = 0; rv = 1; rdata = 32'hB; cyc();
    chk1("t5 B to D", sDrsp, 1'b1);
    rdata = 32'hC; cyc();
    chk1("t5 C to I", sIrsp, 1'b1);
    chk1("t5 C not D", sDrsp, 1'b0);
    idle(); cyc();

    // Unexpected response, sticky error, async reset mid-handshake.
    rv = 1; rdata = 32'hBAD; cyc();
    chk1("t6 no irsp", sIrsp, 1'b0);
    idle(); cyc();
    chk1("t6 err set", err, 1'b1);
    dv = 1; dwr = 0; daddr = 32'h900; mready = 0; cyc();
    chk1("t6 err sticky", err, 1'b1);
    #2;
    doReset();
    rv = 1; rdata = 32'h1; cyc();
    idle(); cyc();
    chk1("t6 err after reset", err, 1'b1);

    // Randomized traffic against the model.
    doReset();
    for (int n = 0; n < 400; n++) begin
      iv     = 1'($urandom_range(0, 1));
      pc     = $urandom & 32'hFFFF_FFFC;
      dv     = 1'($urandom_range(0, 1));
      dwr    = 1'($urandom_range(0, 1));
      daddr  = $urandom;
      dwdata = $urandom;
      dsize  = 2'($urandom_range(0, 2));
      mready = ($urandom_range(0, 3) != 0);
      rv     = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      rdata  = $urandom;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
